uart_rx_path: RTL and testbench

Receive-side counterpart of the transmit path: an oversampling UART receiver feeding a small receive FIFO.
- Deserialises 8N1 frames arriving on `rx`, checks the stop bit and buffers good bytes for the PC/DMA side.
- Pulses `dma_rxend` once per accepted frame, mirroring `dma_txend` on the transmit side.

---
 rtl/uart_pkg.sv | 15 +
 rtl/fifo_rx.sv | 55 +++++
 rtl/uart_rx_path.sv | 126 ++++++++++++
 tb/tb_uart_rx_path.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_FIFO_DEPTH   = 8;

    // Counter width for n distinct values, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rx.sv
// Receive FIFO: circular buffer with first-word fall-through head that reads 0 when empty.
module fifo_rx
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = cnt_width(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign do_rd = rd_en && !empty;
    // A write into a full FIFO is allowed when the head is popped in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_path.sv
// Oversampling 8N1 UART receiver: synchroniser, framing FSM and receive FIFO.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 fifo_rx_status,
    output logic                 fifo_full,
    output logic                 dma_rxend,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_meta, rx_s, rx_prev;
    uart_state_e          state, state_nxt;
    logic [TW-1:0]        tick, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 wr_en;
    logic                 rxend_nxt, ferr_nxt, ovr_nxt;
    logic                 fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            dma_rxend <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            state     <= state_nxt;
            tick      <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            dma_rxend <= rxend_nxt;
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        wr_en     = 1'b0;
        rxend_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        ovr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // Edge-triggered start so a line stuck low cannot retrigger.
                tick_nxt = '0;
                if (rx_prev && !rx_s) state_nxt = START;
            end
            START: begin
                if (tick == TICK_HALF) begin
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == TICK_FULL) begin
                    tick_nxt  = '0;
                    shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                    bit_nxt   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick == TICK_FULL) begin
                    tick_nxt  = '0;
                    state_nxt = IDLE;
                    if (!rx_s) begin
                        ferr_nxt = 1'b1;
                    end else if (!fifo_full || rd_en) begin
                        wr_en     = 1'b1;
                        rxend_nxt = 1'b1;
                    end else begin
                        ovr_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    fifo_rx #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .din   (shift),
        .rd_en (rd_en),
        .dout  (data_out),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign fifo_rx_status = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_path.sv
// Randomised and directed bench for uart_rx_path against a queue-based frame model.
module tb_uart_rx_path;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx    = 1'b1;
    logic          rd_en = 1'b0;
    logic [DB-1:0] data_out;
    logic          fifo_rx_status, fifo_full, dma_rxend, frame_err, overrun;

    uart_rx_path #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .fifo_rx_status (fifo_rx_status),
        .fifo_full      (fifo_full),
        .dma_rxend      (dma_rxend),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor, sampled mid-cycle.
    int   cyc = 0;
    int   n_rxend = 0, n_ferr = 0, n_ovr = 0;
    int   rxend_cyc = -1, stat_rise_cyc = -1;
    logic stat_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dma_rxend) begin
            n_rxend   <= n_rxend + 1;
            rxend_cyc <= cyc;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if (fifo_rx_status && !stat_d) stat_rise_cyc <= cyc;
        stat_d <= fifo_rx_status;
    end

    // Reference model: bytes expected in the FIFO plus expected pulse totals.
    logic [DB-1:0] exp_q[$];
    int e_rxend = 0, e_ferr = 0, e_ovr = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) step();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_status"}, {31'd0, fifo_rx_status}, {31'd0, exp_q.size() > 0});
        chk({tag, "_full"}, {31'd0, fifo_full}, {31'd0, exp_q.size() == DEPTH});
        chk({tag, "_head"}, {24'd0, data_out}, (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'd0);
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "_rxend"}, n_rxend, e_rxend);
        chk({tag, "_ferr"}, n_ferr, e_ferr);
        chk({tag, "_ovr"}, n_ovr, e_ovr);
    endtask

    task automatic model_pop(input string tag);
        chk(tag, {24'd0, data_out}, (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_read();
        model_pop("rd_data");
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk_state("after_rd");
    endtask

    // One 8N1 frame; optionally pops the FIFO on the exact stop-sample cycle.
    task automatic send(input logic [DB-1:0] v, input logic stop, input bit rd_stop);
        hold(1'b1, 3);
        start_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < DB; i++) hold(v[i], CPB);
        rx = stop;
        if (rd_stop) begin
            repeat (10) step();
            model_pop("rd_at_stop");
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            repeat (CPB - 11) step();
        end else begin
            repeat (CPB) step();
        end
        if (!stop) e_ferr++;
        else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(v);
            e_rxend++;
        end else e_ovr++;
        chk_pulses("frame");
        chk_state("frame");
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_pulses", {29'd0, dma_rxend, frame_err, overrun}, 32'd0);
        chk("rst_flags", {30'd0, fifo_rx_status, fifo_full}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // Basic byte, with latency of rxend/status from the frame start.
        send(8'hA5, 1'b1, 1'b0);
        chk("t1_rxend_lat", rxend_cyc - start_cyc, 32'd155);
        chk("t1_stat_lat", stat_rise_cyc - start_cyc, 32'd155);
        do_read();
        do_read();

        // Short glitch must not start a frame.
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, CPB);
        chk_pulses("t2_glitch");
        send(8'h3C, 1'b1, 1'b0);
        do_read();

        // Framing error, then a long break that must not retrigger.
        send(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 100);
        chk_pulses("t3_break");
        send(8'h81, 1'b1, 1'b0);
        do_read();

        // Fill and overrun.
        for (int i = 1; i <= 9; i++) begin
            send(i[7:0], 1'b1, 1'b0);
            if (i == 8) chk("t4_full", {31'd0, fifo_full}, 32'd1);
        end
        chk("t4_ovr", n_ovr, 32'd1);
        for (int i = 0; i < DEPTH; i++) do_read();
        chk("t4_empty", {31'd0, fifo_rx_status}, 32'd0);

        // Write into a full FIFO with a same-cycle read.
        for (int i = 1; i <= 8; i++) send(i[7:0], 1'b1, 1'b0);
        send(8'h77, 1'b1, 1'b1);
        chk("t5_full", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) do_read();

        // Reset during data bit 4 of 0xFF.
        send(8'h11, 1'b1, 1'b0);
        hold(1'b1, 3);
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b1, CPB);
        rx = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        #2;
        chk("t6_rst_out", {22'd0, data_out, fifo_rx_status, fifo_full, dma_rxend, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (8 + 3 * CPB + CPB + 4) step();
        chk_pulses("t6_after_rst");
        chk_state("t6_after_rst");
        send(8'h5A, 1'b1, 1'b0);
        do_read();

        // Randomised traffic: errors, glitches, reads at stop, empty reads.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                hold(1'b1, 3);
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, CPB);
            end
            send(8'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0));
            for (int r = $urandom_range(0, 2); r > 0; r--) do_read();
        end
        while (exp_q.size() > 0) do_read();
        do_read();
        chk_pulses("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
